rssb_sequencer: RTL and testbench

Instruction sequencer for the RSSB (reverse-subtract-and-skip-if-borrow) core. It fetches each instruction word and reads the operand. It computes `operand - accumulator`, writes the result to memory and to the accumulator, and advances the program counter by 1 or 2. The PC and accumulator are external `register` instances: this block drives their `write`/`in` and reads their `out`. It also drives the synchronous data memory directly.

---
 rtl/rssb_sequencer.sv | 119 +++++++++++
 tb/tb_rssb_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rssb_sequencer.sv
// Fetch/decode/execute sequencer for a reverse-subtract-and-skip-if-borrow core.
// The PC and accumulator live in external registers; this block only steers them.
module rssb_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] pc,
    output logic             pc_write,
    output logic [WIDTH-1:0] pc_next,
    input  logic [WIDTH-1:0] acc,
    output logic             acc_write,
    output logic [WIDTH-1:0] acc_next,
    output logic             halted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_q;

    logic [WIDTH-1:0]        operand;
    logic signed [WIDTH:0]   diff;
    logic [WIDTH-1:0]        r;
    logic                    skip;
    logic [WIDTH-1:0]        step;

    // One extra bit keeps the borrow (true signed less-than) even on overflow.
    function automatic logic signed [WIDTH:0] rsub(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH:0] ae;
        logic signed [WIDTH:0] be;
        ae = a;
        be = b;
        return ae - be;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
        end else begin
            case (state_q)
                IDLE:    if (run) state_q <= FETCH;
                FETCH:   state_q <= DECODE;
                DECODE: begin
                    x_q     <= mem_rdata;
                    state_q <= (mem_rdata == '1) ? HALT : EXEC;
                end
                EXEC:    state_q <= run ? FETCH : IDLE;
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Address 0 aliases the PC for operand access.
    always_comb begin
        operand = (x_q == '0) ? pc : mem_rdata;
        diff    = rsub(operand, acc);
        r       = diff[WIDTH-1:0];
        skip    = diff[WIDTH];
        step    = skip ? WIDTH'(2) : WIDTH'(1);
    end

    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        pc_write  = 1'b0;
        pc_next   = '0;
        acc_write = 1'b0;
        acc_next  = '0;
        halted    = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_rd   = 1'b1;
                    mem_addr = pc;
                end
                DECODE: begin
                    if (mem_rdata != '1 && mem_rdata != '0) begin
                        mem_rd   = 1'b1;
                        mem_addr = mem_rdata;
                    end
                end
                EXEC: begin
                    acc_write = 1'b1;
                    acc_next  = r;
                    pc_write  = 1'b1;
                    if (x_q != '0) begin
                        mem_wr    = 1'b1;
                        mem_addr  = x_q;
                        mem_wdata = r;
                        pc_next   = pc + step;
                    end else begin
                        pc_next = r;
                    end
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rssb_sequencer.sv
// Directed bench for rssb_sequencer with a memory, PC and accumulator model around it.
module tb_rssb_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] mem_addr, mem_rdata, mem_wdata;
    logic       mem_rd, mem_wr;
    logic [7:0] pc_q, pc_next, acc_q, acc_next;
    logic       pc_write, acc_write, halted;

    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_waddr = 8'h00, tb_wdata = 8'h00;
    logic       ld = 1'b0;
    logic [7:0] ld_pc = 8'h00, ld_acc = 8'h00;

    int n_chk = 0;
    int n_fail = 0;

    rssb_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .pc(pc_q), .pc_write(pc_write), .pc_next(pc_next),
        .acc(acc_q), .acc_write(acc_write), .acc_next(acc_next),
        .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        else if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (ld) begin
            pc_q  <= ld_pc;
            acc_q <= ld_acc;
        end else begin
            if (pc_write) pc_q <= pc_next;
            if (acc_write) acc_q <= acc_next;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] p, input logic [7:0] a);
        @(negedge clk);
        rst = 1'b1; run = 1'b0; ld = 1'b1; ld_pc = p; ld_acc = a;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; ld = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    typedef struct {
        logic [7:0] pc0, acc0, x, op, r, pc1;
        logic       wr;
    } vec_t;
    vec_t vt[8];

    task automatic run_vec(input int i, input vec_t v);
        do_reset(v.pc0, v.acc0);
        poke(v.pc0, v.x);
        if (v.x != 8'h00) poke(v.x, v.op);
        run = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_fetch", i), {mem_rd, mem_wr, mem_addr}, {1'b1, 1'b0, v.pc0});
        @(negedge clk);
        chk($sformatf("v%0d_decode", i), {mem_rd, mem_wr, mem_addr},
            (v.x != 8'h00) ? {1'b1, 1'b0, v.x} : 10'h0);
        @(negedge clk);
        chk($sformatf("v%0d_exec_acc", i), {acc_write, acc_next}, {1'b1, v.r});
        chk($sformatf("v%0d_exec_pc", i), {pc_write, pc_next}, {1'b1, v.pc1});
        chk($sformatf("v%0d_exec_mem", i), {mem_rd, mem_wr, mem_addr, mem_wdata},
            v.wr ? {1'b0, 1'b1, v.x, v.r} : 18'h0);
        run = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_regs", i), {acc_q, pc_q}, {v.r, v.pc1});
        if (v.wr) chk($sformatf("v%0d_memval", i), mem[v.x], v.r);
        chk($sformatf("v%0d_idle", i), {mem_rd, mem_wr, pc_write, acc_write}, 4'h0);
    endtask

    initial begin
        vt[0] = '{8'h00, 8'h03, 8'h08, 8'h0A, 8'h07, 8'h01, 1'b1};
        vt[1] = '{8'h00, 8'h05, 8'h08, 8'h02, 8'hFD, 8'h02, 1'b1};
        vt[2] = '{8'h00, 8'h01, 8'h08, 8'h80, 8'h7F, 8'h02, 1'b1};
        vt[3] = '{8'h00, 8'hFF, 8'h08, 8'h7F, 8'h80, 8'h01, 1'b1};
        vt[4] = '{8'h04, 8'h01, 8'h00, 8'h00, 8'h03, 8'h03, 1'b0};
        vt[5] = '{8'hFE, 8'h01, 8'h10, 8'h00, 8'hFF, 8'h00, 1'b1};
        vt[6] = '{8'h20, 8'h05, 8'h30, 8'h05, 8'h00, 8'h21, 1'b1};
        vt[7] = '{8'h21, 8'h80, 8'h40, 8'h01, 8'h81, 8'h22, 1'b1};

        // Reset then idle with run low: every output stays 0.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle_c%0d", c),
                {mem_addr, mem_rd, mem_wr, mem_wdata, pc_write, pc_next,
                 acc_write, acc_next, halted}, 64'h0);
        end

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // Back-to-back instructions: second FETCH 3 cycles after the first.
        do_reset(8'h00, 8'h03);
        poke(8'h00, 8'h08);
        poke(8'h01, 8'h08);
        poke(8'h08, 8'h0A);
        run = 1'b1;
        @(negedge clk);
        chk("b2b_fetch0", {mem_rd, mem_addr}, {1'b1, 8'h00});
        @(negedge clk);
        @(negedge clk);
        chk("b2b_exec0", acc_next, 8'h07);
        @(negedge clk);
        chk("b2b_fetch1", {mem_rd, mem_addr}, {1'b1, 8'h01});
        @(negedge clk);
        @(negedge clk);
        chk("b2b_exec1", {acc_next, pc_next, mem_wdata}, {8'h00, 8'h02, 8'h00});
        run = 1'b0;
        @(negedge clk);
        chk("b2b_regs", {acc_q, pc_q, mem[8]}, {8'h00, 8'h02, 8'h00});

        // Halt opcode: halted stays up with run high until reset.
        do_reset(8'h00, 8'h00);
        poke(8'h00, 8'hFF);
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("halt_decode", {mem_rd, mem_wr, pc_write, acc_write, halted}, 5'h0);
        @(negedge clk);
        chk("halt_enter", {mem_rd, mem_wr, pc_write, acc_write, halted}, 5'h01);
        for (int c = 0; c < 5; c++) @(negedge clk);
        chk("halt_hold", {halted, mem_rd, pc_q, acc_q}, {1'b1, 1'b0, 16'h0});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        @(negedge clk);
        chk("halt_cleared", {halted, mem_rd}, 2'b00);

        // Reset asserted during EXEC blocks all writes.
        do_reset(8'h00, 8'h03);
        poke(8'h00, 8'h08);
        poke(8'h08, 8'h0A);
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_exec_strobes", {mem_wr, pc_write, acc_write}, 3'b000);
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        chk("rst_exec_state", {mem[8], acc_q, pc_q}, {8'h0A, 8'h03, 8'h00});
        @(negedge clk);
        chk("rst_exec_idle", {mem_rd, halted}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
